// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Central stall/flush sequencer for the 16-bit 5-stage MIPS pipeline. It drives
// the write enables and the flush/bubble controls of the PC, IF/ID, ID/EX,
// EX/MEM and MEM/WB registers. It detects load-use hazards, sequences the
// flush window after a taken branch, freezes the whole pipe while data memory
// is busy, and raises a sticky timeout fault if memory stays busy too long.
//
// The outputs are combinational from the state and the inputs, so a hazard is
// handled in the same cycle it appears. The FSM updates on posedge clk, and
// the pipeline registers latch on negedge.
//
// Parameters
//   REG_AW        register-address width (R0 is hardwired zero)
//   FLUSH_CYCLES  cycles ifid_flush/idex_bubble are held after a taken branch (1..7)
//   MEM_WAIT_MAX  consecutive mem_busy cycles before the fault is raised (1..255)
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   idex_memread, idex_rd      the load in EX and its destination register
//   ifid_rs, ifid_rt           source registers of the instruction in ID
//   ifid_uses_rt               the ID instruction actually reads rt
//   ex_branch_taken            a branch or jump resolved taken in EX
//   mem_busy                   data memory is not ready this cycle
//   pc_write, ifid_write       PC and IF/ID load enables
//   ifid_flush, idex_bubble    IF/ID clear to NOP; ID/EX control fields cleared
//   exmem_en, memwb_en         EX/MEM and MEM/WB load enables
//   mem_timeout                sticky memory-timeout fault
//   stall_cnt                  (HAZARD_STATS_EN only) saturating count of
//                              cycles with pc_write low
//
// Optional feature: define HAZARD_STATS_EN to add the stall_cnt port and its
// counter.
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int REG_AW       = 3,
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              idex_memread,
    input  logic [REG_AW-1:0] idex_rd,
    input  logic [REG_AW-1:0] ifid_rs,
    input  logic [REG_AW-1:0] ifid_rt,
    input  logic              ifid_uses_rt,
    input  logic              ex_branch_taken,
    input  logic              mem_busy,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              exmem_en,
    output logic              memwb_en,
    output logic              mem_timeout
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    typedef enum logic [1:0] {RUN, FLUSH, MEM_WAIT, FAULT} state_t;

    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [7:0] WAIT_MAX     = 8'(MEM_WAIT_MAX);

    state_t      state_q, state_d;
    state_t      eff_state;
    logic [2:0]  flush_cnt_q, flush_cnt_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        ret_flush_q, ret_flush_d;
    logic        load_use;

    // A load in EX writing a register that the ID instruction reads. Writes to
    // R0 are discarded, so they never create a dependence.
    assign load_use = idex_memread && (idex_rd != '0) &&
                      ((idex_rd == ifid_rs) || (ifid_uses_rt && (idex_rd == ifid_rt)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            flush_cnt_q <= '0;
            wait_cnt_q  <= '0;
            ret_flush_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            ret_flush_q <= ret_flush_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        ret_flush_d = ret_flush_q;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        mem_timeout = 1'b0;

        // When memory comes back, the cycle is handled exactly as the saved
        // state would handle it. That lets the flush window resume in the same
        // cycle without losing a count.
        eff_state = state_q;
        if (state_q == MEM_WAIT && !mem_busy) begin
            eff_state = ret_flush_q ? FLUSH : RUN;
        end

        case (eff_state)
            RUN, FLUSH: begin
                if (mem_busy) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    exmem_en    = 1'b0;
                    memwb_en    = 1'b0;
                    ret_flush_d = (eff_state == FLUSH);
                    wait_cnt_d  = 8'd1;
                    state_d     = (WAIT_MAX <= 8'd1) ? FAULT : MEM_WAIT;
                end else if (ex_branch_taken) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d     = FLUSH;
                        flush_cnt_d = FLUSH_RELOAD;
                    end else begin
                        state_d = RUN;
                    end
                end else if (eff_state == FLUSH) begin
                    // The ID instruction is discarded anyway, so a load-use
                    // match against it does not matter here.
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    if (flush_cnt_q <= 3'd1) begin
                        state_d     = RUN;
                        flush_cnt_d = '0;
                    end else begin
                        state_d     = FLUSH;
                        flush_cnt_d = flush_cnt_q - 3'd1;
                    end
                end else begin
                    state_d = RUN;
                    if (load_use) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                    end
                end
            end
            MEM_WAIT: begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                exmem_en   = 1'b0;
                memwb_en   = 1'b0;
                wait_cnt_d = wait_cnt_q + 8'd1;
                if ((wait_cnt_q + 8'd1) >= WAIT_MAX) begin
                    state_d = FAULT;
                end
            end
            default: begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                exmem_en    = 1'b0;
                memwb_en    = 1'b0;
                mem_timeout = 1'b1;
            end
        endcase

        // While reset is held, keep the pipe quiet and the ID/EX contents
        // harmless.
        if (!rst_n) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            exmem_en    = 1'b0;
            memwb_en    = 1'b0;
            mem_timeout = 1'b0;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Counts every cycle in which the PC is held. The counter saturates
    // instead of wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_write && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//
// Directed-vector bench for pipeline_hazard_ctrl, built with FLUSH_CYCLES=3 and
// MEM_WAIT_MAX=15. The control outputs are packed as
// {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_en, memwb_en, mem_timeout}
// and compared against hand-derived constants. Inputs change 1ns after posedge.
// Outputs are sampled a few ns later, before the next posedge.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

    localparam logic [6:0] O_RUN    = 7'b1100110;
    localparam logic [6:0] O_LDUSE  = 7'b0001110;
    localparam logic [6:0] O_FLUSH  = 7'b1111110;
    localparam logic [6:0] O_FREEZE = 7'b0000000;
    localparam logic [6:0] O_FAULT  = 7'b0000001;
    localparam logic [6:0] O_RESET  = 7'b0011000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       idex_memread = 1'b0;
    logic [2:0] idex_rd = '0;
    logic [2:0] ifid_rs = '0;
    logic [2:0] ifid_rt = '0;
    logic       ifid_uses_rt = 1'b0;
    logic       ex_branch_taken = 1'b0;
    logic       mem_busy = 1'b0;
    logic       pc_write, ifid_write, ifid_flush, idex_bubble;
    logic       exmem_en, memwb_en, mem_timeout;
    logic [6:0] outs;
`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cnt;
`endif

    int vec_count  = 0;
    int fail_count = 0;

    assign outs = {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_en, memwb_en, mem_timeout};

    pipeline_hazard_ctrl #(
        .REG_AW      (3),
        .FLUSH_CYCLES(3),
        .MEM_WAIT_MAX(15)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .idex_memread   (idex_memread),
        .idex_rd        (idex_rd),
        .ifid_rs        (ifid_rs),
        .ifid_rt        (ifid_rt),
        .ifid_uses_rt   (ifid_uses_rt),
        .ex_branch_taken(ex_branch_taken),
        .mem_busy       (mem_busy),
        .pc_write       (pc_write),
        .ifid_write     (ifid_write),
        .ifid_flush     (ifid_flush),
        .idex_bubble    (idex_bubble),
        .exmem_en       (exmem_en),
        .memwb_en       (memwb_en),
        .mem_timeout    (mem_timeout)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cnt      (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Counts one vector and reports it if the observed value differs.
    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vec_count++;
        if (obs !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // Drives one set of inputs and lets the combinational outputs settle.
    task automatic applyStimulus(input logic memread, input logic [2:0] rd, input logic [2:0] rs,
                                 input logic [2:0] rt, input logic uses_rt, input logic br,
                                 input logic busy);
        idex_memread    = memread;
        idex_rd         = rd;
        ifid_rs         = rs;
        ifid_rt         = rt;
        ifid_uses_rt    = uses_rt;
        ex_branch_taken = br;
        mem_busy        = busy;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds rst_n low between clock edges, then releases it away from an edge.
    task automatic pulseReset();
        rst_n = 1'b0;
        #1;
        checkOutput("reset_immediate", 16'(outs), 16'(O_RESET));
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        #2;
        checkOutput("reset_hold", 16'(outs), 16'(O_RESET));
        step();
        checkOutput("reset_after_edge", 16'(outs), 16'(O_RESET));
        rst_n = 1'b1;
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("run_idle", 16'(outs), 16'(O_RUN));

        // Load-use stall for one cycle, then normal flow.
        applyStimulus(1, 3, 3, 0, 0, 0, 0);
        checkOutput("loaduse_rs", 16'(outs), 16'(O_LDUSE));
        step();
        applyStimulus(0, 3, 3, 0, 0, 0, 0);
        checkOutput("loaduse_release", 16'(outs), 16'(O_RUN));

        // R0 destination and an unused rt never stall.
        applyStimulus(1, 0, 0, 0, 1, 0, 0);
        checkOutput("loaduse_r0", 16'(outs), 16'(O_RUN));
        applyStimulus(1, 5, 2, 5, 0, 0, 0);
        checkOutput("loaduse_rt_unused", 16'(outs), 16'(O_RUN));
        applyStimulus(1, 5, 2, 5, 1, 0, 0);
        checkOutput("loaduse_rt_used", 16'(outs), 16'(O_LDUSE));
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        // A taken branch flushes for exactly three cycles.
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        checkOutput("branch_c1", 16'(outs), 16'(O_FLUSH));
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("branch_c2", 16'(outs), 16'(O_FLUSH));
        step();
        checkOutput("branch_c3", 16'(outs), 16'(O_FLUSH));
        step();
        checkOutput("branch_done", 16'(outs), 16'(O_RUN));

        // A branch in the same cycle as a load-use hazard wins, and the flush still spans three cycles.
        applyStimulus(1, 4, 4, 0, 0, 1, 0);
        checkOutput("branch_over_loaduse", 16'(outs), 16'(O_FLUSH));
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            checkOutput("branch_lu_flush", 16'(outs), 16'(O_FLUSH));
            step();
        end
        checkOutput("branch_lu_done", 16'(outs), 16'(O_RUN));

        // A second branch during FLUSH reloads the counter.
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        step();
        checkOutput("reload_branch", 16'(outs), 16'(O_FLUSH));
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            checkOutput("reload_flush", 16'(outs), 16'(O_FLUSH));
            step();
        end
        checkOutput("reload_done", 16'(outs), 16'(O_RUN));

        // mem_busy during flush cycle 2 freezes for 4 cycles, then the flush resumes.
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            checkOutput("flush_freeze", 16'(outs), 16'(O_FREEZE));
            step();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("flush_resume_1", 16'(outs), 16'(O_FLUSH));
        step();
        checkOutput("flush_resume_2", 16'(outs), 16'(O_FLUSH));
        step();
        checkOutput("flush_resume_done", 16'(outs), 16'(O_RUN));

        // mem_busy has priority over a taken branch.
        applyStimulus(0, 0, 0, 0, 0, 1, 1);
        checkOutput("busy_over_branch", 16'(outs), 16'(O_FREEZE));
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("busy_return_run", 16'(outs), 16'(O_RUN));
        step();

        // Busy for 20 cycles: the pipe freezes for the first 15, and the fault holds after that.
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        for (int i = 1; i <= 20; i++) begin
            checkOutput((i <= 15) ? "timeout_freeze" : "timeout_fault", 16'(outs),
                        16'((i <= 15) ? O_FREEZE : O_FAULT));
            step();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("fault_sticky", 16'(outs), 16'(O_FAULT));
        step();
        checkOutput("fault_sticky_2", 16'(outs), 16'(O_FAULT));
        pulseReset();
        step();
        checkOutput("fault_cleared", 16'(outs), 16'(O_RUN));

        // Reset taken in the middle of MEM_WAIT, with no clock edge.
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        step();
        checkOutput("memwait_before_reset", 16'(outs), 16'(O_FREEZE));
        pulseReset();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
`ifdef HAZARD_STATS_EN
        checkOutput("stall_cnt_zero", stall_cnt, 16'd0);
`endif
        step();
        checkOutput("run_after_reset", 16'(outs), 16'(O_RUN));
        applyStimulus(1, 6, 6, 0, 0, 0, 0);
        step();
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("run_after_stalls", 16'(outs), 16'(O_RUN));
`ifdef HAZARD_STATS_EN
        checkOutput("stall_cnt_two", stall_cnt, 16'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, fail_count);
        $finish;
    end

endmodule
